win_detector: RTL and testbench



---
 rtl/win_detector.sv | 168 ++++++++++++++++
 tb/tb_win_detector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/win_detector.sv
// Post-move line checker: walks outward from the landing cell in four directions
// through the board's combinational read port and reports a WIN_LEN run.
module win_detector #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] move_row,
    input  logic [2:0] move_col,
    input  logic [1:0] player,
    output logic       rd_en,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] win_dir
);
    localparam int CW   = 4;
    localparam int STW  = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam int CNTW = $clog2(WIN_LEN + 1);
    localparam logic [CW-2:0] ROW_MAX = 3'(ROWS - 1);
    localparam logic [CW-2:0] COL_MAX = 3'(COLS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_q, row_d, col_q, col_d;
    logic [1:0]        player_q, player_d;
    logic [1:0]        dir_q, dir_d;
    logic              side_q, side_d;       // 0: +step side, 1: -step side
    logic [STW-1:0]    step_q, step_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              win_q, win_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]        win_dir_q, win_dir_d;

    logic signed [CW-1:0] step_s, d_row, d_col, cand_row, cand_col;
    logic                 in_bounds, match, side_end;
    logic [CNTW-1:0]      count_inc;

    // Candidate coordinate: one bit wider and signed so off-board cells are negative
    // or beyond the max index rather than aliasing onto the board.
    always_comb begin
        step_s = signed'(CW'(step_q));
        d_row  = (dir_q == 2'd0) ? '0 : step_s;
        case (dir_q)
            2'd1:    d_col = '0;
            2'd3:    d_col = -step_s;
            default: d_col = step_s;
        endcase
        if (side_q) begin
            d_row = -d_row;
            d_col = -d_col;
        end
        cand_row  = signed'({1'b0, row_q}) + d_row;
        cand_col  = signed'({1'b0, col_q}) + d_col;
        in_bounds = !cand_row[CW-1] && !cand_col[CW-1] &&
                    (cand_row[CW-2:0] <= ROW_MAX) && (cand_col[CW-2:0] <= COL_MAX);
        rd_en     = (state_q == SCAN) && in_bounds;
        rd_row    = rd_en ? cand_row[CW-2:0] : '0;
        rd_col    = rd_en ? cand_col[CW-2:0] : '0;
        match     = rd_en && (rd_data == player_q);
        count_inc = count_q + CNTW'(1);
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        player_d  = player_q;
        dir_d     = dir_q;
        side_d    = side_q;
        step_d    = step_q;
        count_d   = count_q;
        win_d     = win_q;
        win_dir_d = win_dir_q;
        side_end  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                win_d     = 1'b0;
                win_dir_d = 2'd0;
                if (player == 2'b01 || player == 2'b10) begin
                    row_d    = move_row;
                    col_d    = move_col;
                    player_d = player;
                    dir_d    = 2'd0;
                    side_d   = 1'b0;
                    step_d   = STW'(1);
                    count_d  = CNTW'(1);
                    state_d  = SCAN;
                end else begin
                    state_d = DONE;
                end
            end
            SCAN: begin
                if (match) begin
                    count_d = count_inc;
                    if (count_inc >= CNTW'(WIN_LEN)) begin
                        win_d     = 1'b1;
                        win_dir_d = dir_q;
                        state_d   = DONE;
                    end else if (step_q == STW'(WIN_LEN - 1)) begin
                        side_end = 1'b1;
                    end else begin
                        step_d = step_q + STW'(1);
                    end
                end else begin
                    side_end = 1'b1;
                end
                if (side_end) begin
                    step_d = STW'(1);
                    if (!side_q) begin
                        side_d = 1'b1;
                    end else if (dir_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        side_d  = 1'b0;
                        dir_d   = dir_q + 2'd1;
                        count_d = CNTW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SCAN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            player_q  <= '0;
            dir_q     <= '0;
            side_q    <= 1'b0;
            step_q    <= '0;
            count_q   <= '0;
            win_q     <= 1'b0;
            win_dir_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            player_q  <= player_d;
            dir_q     <= dir_d;
            side_q    <= side_d;
            step_q    <= step_d;
            count_q   <= count_d;
            win_q     <= win_d;
            win_dir_q <= win_dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign win     = win_q;
    assign win_dir = win_dir_q;
endmodule

// File: tb/tb_win_detector.sv
// Scoreboard bench for win_detector: directed boards with hand-computed results,
// scan length and read counts checked by an independent monitor.
module tb_win_detector;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [2:0] move_row = '0, move_col = '0;
    logic [1:0] player = '0;
    logic       rd_en, busy, done, win;
    logic [2:0] rd_row, rd_col;
    logic [1:0] rd_data, win_dir;
    logic [1:0] board [8][8];

    win_detector #(.ROWS(8), .COLS(8), .WIN_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move_row(move_row), .move_col(move_col),
        .player(player), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .busy(busy), .done(done), .win(win), .win_dir(win_dir)
    );

    assign rd_data = rd_en ? board[rd_row][rd_col] : 2'b00;
    always #5 clk = ~clk;

    typedef struct {
        logic       win;
        logic [1:0] dir;
        int         cycles;
        int         reads;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int n_vec = 0, n_bad = 0;
    int busy_cnt = 0, rd_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: count scan/read cycles, compare against the queued expectation on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            rd_cnt   = 0;
        end else begin
            if (busy)  busy_cnt++;
            if (rd_en) rd_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e_mon = q.pop_front();
                    chk("win", int'(win), int'(e_mon.win));
                    chk("win_dir", int'(win_dir), int'(e_mon.dir));
                    chk("scan_cycles", busy_cnt, e_mon.cycles);
                    chk("reads", rd_cnt, e_mon.reads);
                end
                busy_cnt = 0;
                rd_cnt   = 0;
            end
        end
    end

    task automatic clear_board();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) board[r][c] = 2'b00;
    endtask

    task automatic put(input int r, input int c, input logic [1:0] v);
        board[r][c] = v;
    endtask

    task automatic run(input int r, input int c, input int p, input logic ew, input int ed,
                       input int ec, input int er, input int poke);
        exp_t e;
        e.win = ew; e.dir = 2'(ed); e.cycles = ec; e.reads = er;
        q.push_back(e);
        @(posedge clk); #1;
        move_row = 3'(r); move_col = 3'(c); player = 2'(p); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke > 0) begin
            repeat (poke - 1) @(posedge clk);
            #1 start = 1'b1; move_row = 3'd0; move_col = 3'd0; player = 2'b01;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        chk("win_hold", int'(win), int'(ew));
        chk("win_dir_hold", int'(win_dir), ed);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic setup_col5();
        clear_board();
        for (int r = 0; r < 4; r++) put(r, 5, 2'b10);
    endtask

    task automatic setup_row0();
        clear_board();
        for (int c = 0; c < 4; c++) put(0, c, 2'b01);
    endtask

    initial begin
        clear_board();
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_win_dir", int'(win_dir), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Corner, lone piece: 8 scan cycles, only 3 in-bounds reads.
        put(0, 0, 2'b01);
        run(0, 0, 1, 1'b0, 0, 8, 3, 0);
        // Horizontal win found on neg side.
        setup_row0();
        run(0, 3, 1, 1'b1, 0, 4, 4, 0);
        // Vertical win for player 10.
        setup_col5();
        run(3, 5, 2, 1'b1, 1, 6, 6, 0);
        // Anti-diagonal win, then blocked variant scanning to the end.
        clear_board();
        put(0, 6, 2'b01); put(1, 5, 2'b01); put(3, 3, 2'b01); put(2, 4, 2'b01);
        run(2, 4, 1, 1'b1, 3, 10, 10, 0);
        put(3, 3, 2'b10);
        run(2, 4, 1, 1'b0, 0, 10, 9, 0);
        // Opponent pieces cap the run at 3.
        clear_board();
        put(0, 0, 2'b10); put(0, 1, 2'b01); put(0, 2, 2'b01); put(0, 3, 2'b01); put(0, 4, 2'b10);
        run(0, 3, 1, 1'b0, 0, 10, 7, 0);
        // Extra start during scan must be ignored.
        setup_col5();
        run(3, 5, 2, 1'b1, 1, 6, 6, 3);
        // Invalid players clear a held win and finish without reading.
        setup_row0();
        run(0, 3, 1, 1'b1, 0, 4, 4, 0);
        run(2, 2, 0, 1'b0, 0, 0, 0, 0);
        run(2, 2, 3, 1'b0, 0, 0, 0, 0);

        // Asynchronous reset mid-scan.
        clear_board();
        put(0, 0, 2'b01);
        @(posedge clk); #1 move_row = 3'd0; move_col = 3'd0; player = 2'b01; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("scan_busy_before_rst", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_win", int'(win), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("post_rst_busy", int'(busy), 0);

        // Block still works after the reset.
        setup_row0();
        run(0, 3, 1, 1'b1, 0, 4, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
